// File: rtl/cordic_iter.sv
// Iterative CORDIC engine (rotating / vectoring), one micro-rotation per clock behind a put/get handshake.
// Optional macro CORDIC_GAIN_COMP_EN adds a COMP state that scales x/y by 1/K before the result is offered.
module cordic_iter #(
    parameter int W    = 16,
    parameter int ITER = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3*W:0]     request_put,
    input  logic             EN_request_put,
    output logic             RDY_request_put,
    output logic [3*W+1:0]   response_get,
    input  logic             EN_response_get,
    output logic             RDY_response_get
);
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int DW = W + 2;
    localparam logic [IW-1:0] LAST_ITER   = IW'(ITER - 1);
    localparam logic [IW-1:0] ITER_ONE    = IW'(1);
    localparam logic [W-1:0]  HALF_PI     = {2'b01, {(W-2){1'b0}}};
    localparam logic [W-1:0]  NEG_HALF_PI = {2'b11, {(W-2){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_COMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

`ifdef CORDIC_GAIN_COMP_EN
    localparam state_t POST_STATE = S_COMP;
`else
    localparam state_t POST_STATE = S_DONE;
`endif

    // atan(2^-i) in binary-angle units, from a fixed-point Taylor series (2^-64 resolution).
    function automatic logic [W-1:0] atan_calc(input int i);
        logic [127:0] pi_fx;
        logic [127:0] acc;
        logic [127:0] term;
        int           sh;
        pi_fx = 128'h3_243F_6A88_85A3_08D3;
        acc   = 128'd0;
        term  = 128'd0;
        if (i == 0) begin
            acc = pi_fx >> 2;
        end else begin
            for (int k = 0; k < 64; k++) begin
                sh = 64 - i * (2 * k + 1);
                if (sh >= 0) begin
                    term = (128'd1 << sh) / 128'(2 * k + 1);
                    if ((k % 2) == 0) begin
                        acc = acc + term;
                    end else begin
                        acc = acc - term;
                    end
                end else begin
                    term = 128'd0;
                end
            end
        end
        atan_calc = W'(((acc << (W - 1)) + (pi_fx >> 1)) / pi_fx);
    endfunction

    logic [W-1:0] atan_tab [2**IW];

    for (genvar g = 0; g < 2**IW; g++) begin : g_atan
        if (g < ITER) begin : g_used
            localparam logic [W-1:0] ATAN_G = atan_calc(g);
            assign atan_tab[g] = ATAN_G;
        end else begin : g_pad
            assign atan_tab[g] = {W{1'b0}};
        end
    end

    state_t               state_q, state_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic                 mode_q, mode_d;
    logic signed [DW-1:0] x_q, x_d, y_q, y_d;
    logic [W-1:0]         z_q, z_d;
    logic                 rdy_put_q, rdy_put_d, rdy_get_q, rdy_get_d;

    logic                 req_mode_s;
    logic [W-1:0]         req_x_s, req_y_s, req_z_s;
    logic signed [DW-1:0] in_x_s, in_y_s, pre_x_s, pre_y_s;
    logic [W-1:0]         pre_z_s;
    logic signed [DW-1:0] x_sh_s, y_sh_s;
    logic                 dir_pos_s;

    assign {req_mode_s, req_x_s, req_y_s, req_z_s} = request_put;
    assign in_x_s    = {{2{req_x_s[W-1]}}, req_x_s};
    assign in_y_s    = {{2{req_y_s[W-1]}}, req_y_s};
    assign x_sh_s    = x_q >>> iter_q;
    assign y_sh_s    = y_q >>> iter_q;
    // d = +1 when z >= 0 (rotating) or y < 0 (vectoring)
    assign dir_pos_s = mode_q ? y_q[DW-1] : ~z_q[W-1];

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = 2 * W + 2;
    localparam logic [W:0] KINV = (W + 1)'($rtoi(0.6072529 * (2.0 ** W) + 0.5));
    localparam logic signed [PW-1:0] ROUND_HALF = {{(W + 2){1'b0}}, 1'b1, {(W - 1){1'b0}}};
    logic signed [PW-1:0] prod_x_s, prod_y_s, rnd_x_s, rnd_y_s;
    logic                 comp_unused_s;

    assign prod_x_s      = $signed({{W{x_q[DW-1]}}, x_q}) * $signed({{(W + 1){1'b0}}, KINV});
    assign prod_y_s      = $signed({{W{y_q[DW-1]}}, y_q}) * $signed({{(W + 1){1'b0}}, KINV});
    assign rnd_x_s       = prod_x_s + ROUND_HALF;
    assign rnd_y_s       = prod_y_s + ROUND_HALF;
    assign comp_unused_s = ^{rnd_x_s[W-1:0], rnd_y_s[W-1:0]};
`endif

    // Fold the request into the convergence range |angle| <= pi/2.
    always_comb begin
        pre_x_s = in_x_s;
        pre_y_s = in_y_s;
        pre_z_s = req_z_s;
        if (req_mode_s == 1'b0) begin
            if ($signed(req_z_s) >= $signed(HALF_PI)) begin
                pre_x_s = -in_y_s;
                pre_y_s = in_x_s;
                pre_z_s = req_z_s - HALF_PI;
            end else if ($signed(req_z_s) < $signed(NEG_HALF_PI)) begin
                pre_x_s = in_y_s;
                pre_y_s = -in_x_s;
                pre_z_s = req_z_s + HALF_PI;
            end else begin
                pre_z_s = req_z_s;
            end
        end else begin
            if (in_x_s[DW-1] && !in_y_s[DW-1]) begin
                pre_x_s = in_y_s;
                pre_y_s = -in_x_s;
                pre_z_s = HALF_PI;
            end else if (in_x_s[DW-1]) begin
                pre_x_s = -in_y_s;
                pre_y_s = in_x_s;
                pre_z_s = NEG_HALF_PI;
            end else begin
                pre_z_s = {W{1'b0}};
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (EN_request_put) begin
                    mode_d  = req_mode_s;
                    x_d     = pre_x_s;
                    y_d     = pre_y_s;
                    z_d     = pre_z_s;
                    iter_d  = {IW{1'b0}};
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (dir_pos_s) begin
                    x_d = x_q - y_sh_s;
                    y_d = y_q + x_sh_s;
                    z_d = z_q - atan_tab[iter_q];
                end else begin
                    x_d = x_q + y_sh_s;
                    y_d = y_q - x_sh_s;
                    z_d = z_q + atan_tab[iter_q];
                end
                if (iter_q == LAST_ITER) begin
                    iter_d  = {IW{1'b0}};
                    state_d = POST_STATE;
                end else begin
                    iter_d  = iter_q + ITER_ONE;
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP: begin
                x_d     = rnd_x_s[PW-1:W];
                y_d     = rnd_y_s[PW-1:W];
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (EN_response_get) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        rdy_put_d = (state_d == S_IDLE);
        rdy_get_d = (state_d == S_DONE);
    end

    // State, datapath and ready registers; RST discards any transaction in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            iter_q    <= {IW{1'b0}};
            mode_q    <= 1'b0;
            x_q       <= {DW{1'b0}};
            y_q       <= {DW{1'b0}};
            z_q       <= {W{1'b0}};
            rdy_put_q <= 1'b1;
            rdy_get_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            mode_q    <= mode_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            rdy_put_q <= rdy_put_d;
            rdy_get_q <= rdy_get_d;
        end
    end

    assign RDY_request_put  = rdy_put_q;
    assign RDY_response_get = rdy_get_q;
    assign response_get     = {x_q[W:0], y_q[W:0], z_q};
endmodule

// File: doc/cordic_iter.md
# cordic_iter

Parametrised iterative CORDIC engine, successor to the fixed 16-bit rotating core. Supports rotating and vectoring modes per request, configurable data width and iteration count. Uses one micro-rotation per cycle and a single shared adder set. Sits behind the same put/get handshake as the earlier core, so testbench and system wrappers attach unchanged apart from width.

## Interface
Parameters:
- W, 16, data width of x, y and z (z in binary-angle units: 2^(W-1) = π).
- ITER, 16, micro-rotation count, 1..W.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- request_put  in  3W+1  {mode, x[W-1:0], y[W-1:0], z[W-1:0]}. mode 0 = rotating, 1 = vectoring. All fields are two's complement.
- EN_request_put  in  1  accept request; legal only while RDY_request_put=1.
- RDY_request_put  out  1  engine idle, can accept.
- response_get  out  3W+2  {x[W:0], y[W:0], z[W-1:0]}.
- EN_response_get  in  1  consume response; legal only while RDY_response_get=1.
- RDY_response_get  out  1  response valid.

## Operation
- FSM states: IDLE → BUSY → (COMP if CORDIC_GAIN_COMP_EN) → DONE → IDLE.
- IDLE: RDY_request_put=1.
  - EN_request_put loads the registers with pre-rotation, then enters BUSY with i=0.
  - Rotating pre-rotation: if z ≥ +π/2, (x,y,z) ← (−y, x, z−π/2). If z < −π/2, (x,y,z) ← (y, −x, z+π/2).
  - Vectoring pre-rotation: if x < 0 and y ≥ 0, (x,y,z) ← (y, −x, +π/2). If x < 0 and y < 0, (x,y,z) ← (−y, x, −π/2). Otherwise z ← 0.
- BUSY, iteration i:
  - Direction d = sign(z) for rotating, −sign(y) for vectoring. Zero counts as positive.
  - x ← x − d·(y>>>i); y ← y + d·(x>>>i); z ← z − d·atan_i.
  - i increments each cycle. After i=ITER−1, go to COMP or DONE.
- atan_i = round(atan(2^−i)·2^(W−1)/π). Built as an elaboration-time table. For W=16: 8192, 4836, 2555, 1297, 651, ...
- Internal x/y datapath is W+2 bits (sign + gain headroom). Output x/y are the low W+1 bits. z is kept W bits and wraps modulo 2π.
- DONE: RDY_response_get=1; response is held stable until EN_response_get, then go to IDLE.
- No request is accepted outside IDLE. No pipelining: one transaction in flight.
- RST in any state: state ← IDLE, i ← 0. Datapath registers cleared. Any in-flight result is discarded.

## Timing
- Reset values: RDY_request_put=1, RDY_response_get=0, response_get=0.
- Request accepted at edge t. RDY_response_get rises at edge t+ITER (t+ITER+1 with compensation).
- RDY_request_put falls the cycle after acceptance. It rises the cycle after EN_response_get.
- Minimum turnaround is ITER+2 cycles per transaction (ITER+3 with compensation).
- Ready outputs are registered functions of state only. There is no combinational path from EN_* to RDY_*.
- If EN_* is asserted while RDY_* is low, it is ignored; a bench assertion flags it.

## Configuration
- Macro: CORDIC_GAIN_COMP_EN.
- Defined:
  - Adds the COMP state (one cycle) after the last iteration.
  - x,y ← round((x,y)·Kinv), where Kinv = round(0.6072529·2^W) is a W+1-bit unsigned constant and the product is rounded to nearest.
  - Outputs are the true rotated/vector magnitude.
  - Latency is ITER+1.
- Undefined:
  - No COMP state; outputs carry the CORDIC gain K≈1.64676 (for ITER=16).
  - Latency is ITER.

## Test plan
W=16, ITER=16, compensation off unless stated. Tolerance ±3 LSB.
- Rotate (0, 10000, 0, 8192) → x≈11645, y≈11645, z≈0. Ready rises exactly 16 cycles after acceptance.
- Vector (1, 10000, 10000, 0) → x≈23290, y≈0, z≈8192.
- Quadrant edge: rotate (0, 10000, 0, −32768) → x≈−16468, y≈0. Vector (1, −10000, 0, 0) → x≈16468, z≈±32767.
- Backpressure: hold EN_response_get low 5 cycles after DONE → response_get constant, RDY_request_put=0 throughout, then one get → IDLE next cycle.
- Reset mid-BUSY (i=7) → next cycle RDY_request_put=1, RDY_response_get=0. A fresh request then produces correct results.
- With CORDIC_GAIN_COMP_EN: rotate (0, 10000, 0, 8192) → x≈y≈7071, latency 17 cycles.
